// File: rtl/riscv_lsu.sv
// riscv_lsu: RISC-V load/store unit between core datapath and byte-lane data memory
// Optional feature macro: MISALIGNED_SPLIT_EN (word-crossing accesses split into two memory cycles;
// when undefined any word-crossing request is rejected with resp_err).
// Ports:
//   clk, rst_b                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write, req_funct3       store/load and RISC-V size/signedness code
//   req_addr, req_wdata         byte address, right-aligned store data
//   resp_valid/rdata/err        one-cycle completion pulse, extended load data, reject flag
//   mem_addr                    word-aligned memory address
//   mem_data_out/mem_data_in    read bytes (combinational) / write bytes, lane i = mem_addr+i
//   mem_write_en                whole-word write at the clock edge
module riscv_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [31:0]     mem_addr,
    input  logic [XLEN-1:0] mem_data_out,
    output logic [XLEN-1:0] mem_data_in,
    output logic            mem_write_en
);
    localparam int LANES = XLEN / 8;
    localparam int OW = $clog2(LANES);
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, RESP} state_t;

    state_t            state, nxt;
    logic [31:0]       addr_q;
    logic [2:0]        f3_q;
    logic              wr_q;
    logic [XLEN-1:0]   wdata_q, buf_a, buf_b;

    // Decode works on the live request while idle and on the latched copy afterwards.
    logic              idle;
    logic [31:0]       addr;
    logic [2:0]        f3;
    logic              wr;
    logic [OW-1:0]     off;
    logic [3:0]        size;
    logic              split, full, illegal;
    logic [31:0]       word_a, word_b;
    logic [OW+2:0]     sh;

    assign idle    = state == IDLE;
    assign addr    = idle ? req_addr : addr_q;
    assign f3      = idle ? req_funct3 : f3_q;
    assign wr      = idle ? req_write : wr_q;
    assign off     = addr[OW-1:0];
    assign size    = 4'd1 << f3[1:0];
    assign sh      = {off, 3'b000};
    assign split   = (5'(off) + 5'(size)) > 5'(LANES);
    assign full    = (5'(size) == 5'(LANES)) && off == '0;
    assign word_a  = {addr[31:OW], {OW{1'b0}}};
    assign word_b  = word_a + 32'(LANES);
    assign illegal = f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)) ||
                     (wr && f3[2]) || (!SPLIT_EN && split);

    // Byte mask of the access size; shifting by >= XLEN yields zero, so a full-width access gives all ones.
    logic [XLEN-1:0]   lomask, msb, low, ext;
    logic [2*XLEN-1:0] cat, merged;
    logic              fill;

    // A read state sees its word on mem_data_out this cycle; earlier words come from the buffers.
    assign cat    = {state == RD_B ? mem_data_out : buf_b, state == RD_A ? mem_data_out : buf_a};
    assign low    = XLEN'(cat >> sh);
    assign lomask = ~({XLEN{1'b1}} << {size, 3'b000});
    assign msb    = lomask & ~(lomask >> 1);
    assign fill   = ~f3[2] & |(low & msb);
    assign ext    = (low & lomask) | ({XLEN{fill}} & ~lomask);
    assign merged = ({buf_b, buf_a} & ~({{XLEN{1'b0}}, lomask} << sh)) |
                    ({{XLEN{1'b0}}, wdata_q & lomask} << sh);

    assign req_ready    = idle;
    assign resp_valid   = state == RESP;
    assign mem_write_en = state == WR_A || state == WR_B;
    assign mem_addr     = (state == RD_A || state == WR_A) ? word_a :
                          (state == RD_B || state == WR_B) ? word_b : '0;
    assign mem_data_in  = state == WR_A ? merged[XLEN-1:0] :
                          state == WR_B ? merged[2*XLEN-1:XLEN] : '0;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (req_valid) nxt = illegal ? RESP : (wr && full) ? WR_A : RD_A;
            RD_A:    nxt = split ? RD_B : wr ? WR_A : RESP;
            RD_B:    nxt = wr ? WR_A : RESP;
            WR_A:    nxt = split ? WR_B : RESP;
            WR_B:    nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            buf_a      <= '0;
            buf_b      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= nxt;
            if (idle && req_valid) begin
                addr_q   <= req_addr;
                f3_q     <= req_funct3;
                wr_q     <= req_write;
                wdata_q  <= req_wdata;
                resp_err <= illegal;
                if (illegal) resp_rdata <= '0;
            end
            if (state == RD_A) buf_a <= mem_data_out;
            if (state == RD_B) buf_b <= mem_data_out;
            if (nxt == RESP && (state == RD_A || state == RD_B) && !wr_q) resp_rdata <= ext;
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized self-checking bench for riscv_lsu against a byte-array reference model
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_write_en;
    logic [31:0] resp_rdata, mem_addr, mem_data_out, mem_data_in;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    riscv_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT (1 KiB window, address bits 9:0) and the reference copy.
    logic [7:0] dmem [1024];
    logic [7:0] ref_mem [1024];
    logic       poke_en = 1'b0;
    logic [9:0] poke_a = '0;
    logic [7:0] poke_d = '0;

    for (genvar i = 0; i < 4; i++) begin : g_rd
        assign mem_data_out[8*i +: 8] = dmem[10'(mem_addr + 32'(i))];
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) dmem[10'(mem_addr + 32'(i))] <= mem_data_in[8*i +: 8];
        end else if (poke_en) begin
            dmem[poke_a] <= poke_d;
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ref_mem[a[9:0]] = d;
        @(negedge clk);
        poke_en = 1'b1;
        poke_a = a[9:0];
        poke_d = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic poke32(input logic [31:0] a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) poke(a + 32'(k), v[8*k +: 8]);
    endtask

    function automatic logic [63:0] peek_dut(input logic [31:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = dmem[10'(a + 32'(k))];
        return r;
    endfunction

    function automatic logic [63:0] peek_ref(input logic [31:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[10'(a + 32'(k))];
        return r;
    endfunction

    // One request: the model predicts legality, latency, write count and data from byte-level rules.
    task automatic run(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
        int          size, off, lat, nw, c, wcnt;
        bit          split, bad, got;
        logic [31:0] exp_rd;
        size   = 1 << f3[1:0];
        off    = int'(a[1:0]);
        split  = off + size > 4;
        bad    = f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110 || (w && f3[2]) || (!EN && split);
        lat    = bad ? 1 : !w ? (split ? 3 : 2) : (size == 4 && off == 0) ? 2 : split ? 5 : 3;
        nw     = (bad || !w) ? 0 : split ? 2 : 1;
        exp_rd = '0;
        if (!bad && !w) begin
            for (int k = 0; k < size; k++) exp_rd[8*k +: 8] = ref_mem[10'(a + 32'(k))];
            if (!f3[2] && exp_rd[8*size-1])
                for (int k = size; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
        end
        if (!bad && w)
            for (int k = 0; k < size; k++) ref_mem[10'(a + 32'(k))] = wd[8*k +: 8];
        @(negedge clk);
        check("ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        c = 0;
        wcnt = 0;
        got = 1'b0;
        while (!got && c < 12) begin
            @(negedge clk);
            c++;
            if (mem_write_en) wcnt++;
            got = resp_valid;
        end
        check("latency", 64'(c), 64'(lat));
        check("resp_err", 64'(resp_err), 64'(bad));
        if (bad || !w) check("rdata", 64'(resp_rdata), 64'(exp_rd));
        check("writes", 64'(wcnt), 64'(nw));
        check("busy", 64'(req_ready), 64'd0);
        if (w && !bad) check("mem", peek_dut(a & 32'hFFFF_FFFC), peek_ref(a & 32'hFFFF_FFFC));
        rd = resp_rdata;
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] snap, w64;
        logic [31:0] a;
        int          seen;
        for (int i = 0; i < 1024; i++) poke(32'(i), 8'($urandom));
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_rdata", 64'(resp_rdata), 64'd0);
        check("rst_we", 64'(mem_write_en), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_din", 64'(mem_data_in), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;

        poke32(32'h100, 32'h1234_5678);
        run(1'b0, 3'b010, 32'h100, 32'h0, rd);
        check("lw_plan", 64'(rd), 64'h1234_5678);
        poke(32'h103, 8'h80);
        run(1'b0, 3'b000, 32'h103, 32'h0, rd);
        check("lb_plan", 64'(rd), 64'hFFFF_FF80);
        run(1'b0, 3'b100, 32'h103, 32'h0, rd);
        check("lbu_plan", 64'(rd), 64'h0000_0080);
        poke32(32'h100, 32'h1122_3344);
        run(1'b1, 3'b000, 32'h101, 32'hAB, rd);
        w64 = peek_dut(32'h100);
        check("sb_plan", 64'(w64[31:0]), 64'h1122_AB44);
        poke32(32'h100, 32'hDDCC_BBAA);
        poke32(32'h104, 32'h4433_2211);
        run(1'b0, 3'b010, 32'h102, 32'h0, rd);
`ifdef MISALIGNED_SPLIT_EN
        check("lw_split_plan", 64'(rd), 64'h2211_DDCC);
`endif
        run(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hBEEF, rd);
        run(1'b0, 3'b111, 32'h100, 32'h0, rd);
        check("f3_111_rdata", 64'(rd), 64'd0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(2))
                0:       a = 32'h100 + 32'($urandom_range(63));
                1:       a = 32'hFFFF_FFE0 + 32'($urandom_range(31));
                default: a = 32'($urandom_range(31));
            endcase
            run(1'($urandom), 3'($urandom), a, $urandom, rd);
        end

        // Reset in the middle of a read-modify-write store: nothing may be written or answered.
        snap = peek_dut(32'h100);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
        req_funct3 = 3'b001;
        req_addr = 32'h103;
`else
        req_funct3 = 3'b000;
        req_addr = 32'h101;
`endif
        req_wdata = 32'h5A5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        repeat (2) @(negedge clk);
`else
        @(negedge clk);
`endif
        rst_b = 1'b0;
        #1 check("midrst_we", 64'(mem_write_en), 64'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || mem_write_en) seen++;
        end
        check("midrst_quiet", 64'(seen), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(req_ready), 64'd1);
        check("midrst_valid", 64'(resp_valid), 64'd0);
        check("midrst_mem", peek_dut(32'h100), snap);
        run(1'b0, 3'b010, 32'h100, 32'h0, rd);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Parametrised load/store unit between the RISC-V core datapath and the byte-lane data memory.
- Handles every RV32I/RV64I load/store width: sign/zero extension, sub-word stores by read-modify-write, and word-crossing (misaligned) accesses split into two memory cycles.
- Replaces direct core-to-memory wiring.
- Memory is read combinationally (mem_data_out valid in the same cycle as mem_addr) and written at the clock edge when mem_write_en=1.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- LANES, XLEN/8, byte lanes per memory word (derived, not overridable).

Ports:
- clk  input  1  clock
- rst_b  input  1  reset, asynchronous, active-low
- req_valid  input  1  request strobe
- req_ready  output  1  unit can accept a request
- req_write  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V funct3 (size/signedness)
- req_addr  input  32  byte address
- req_wdata  input  XLEN  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  XLEN  load result, extended
- resp_err  output  1  request rejected, no memory access performed
- mem_addr  output  32  word-aligned memory address
- mem_data_out  input  8 x LANES  read bytes; lane i = address mem_addr+i
- mem_data_in  output  8 x LANES  write bytes
- mem_write_en  output  1  write whole word at clock edge

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE, so req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_write_en=0, mem_addr=0, all mem_data_in lanes=0.
  - mem_write_en must fall immediately on rst_b assertion (combinational from state).
- Handshake:
  - Accept when req_valid && req_ready in IDLE; latch addr, funct3, write, wdata.
  - req_ready=1 only in IDLE.
  - resp has no backpressure.
  - Next request can be accepted the cycle after the RESP cycle.
- Decode:
  - size = 1/2/4/8 bytes from funct3[1:0].
  - Unsigned when funct3[2]=1 (loads only).
  - off = addr[log2(LANES)-1:0].
  - wordA = addr with off cleared.
  - wordB = wordA+LANES, modulo 2^32 (0xFFFFFFFC+4 wraps to 0x00000000).
  - split = off+size > LANES.
- Illegal requests:
  - funct3 values 111; 011 or 110 when XLEN=32; store with funct3[2]=1.
  - Response: IDLE -> RESP, resp_err=1, resp_rdata=0, no mem access.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, RESP.
  - Load: RD_A -> (RD_B if split) -> RESP.
  - Store, full aligned word (size=LANES, off=0): WR_A -> RESP, no read.
  - Store, other: RD_A -> (RD_B) -> WR_A -> (WR_B) -> RESP.
  - RD_x: mem_addr=wordx, mem_write_en=0; mem_data_out captured into buffer x at the clock edge.
  - WR_x: mem_addr=wordx, mem_write_en=1. mem_data_in = buffer x with the target lanes replaced by store bytes, little-endian; byte k of wdata goes to linear byte off+k across A then B.
- Latency from the accept cycle (cycle 0) to resp_valid:
  - aligned load 2
  - split load 3
  - aligned full-word store 2
  - aligned sub-word store 3
  - split store 5
  - illegal 1
- Load result: bytes off..off+size-1 of A:B concatenation; sign-extended (funct3[2]=0) or zero-extended to XLEN.
- resp_rdata holds its value until the next RESP; resp_err is valid only with resp_valid.
- Reset mid-operation:
  - Returns to IDLE and drops any pending response.
  - A WR_A already committed is not undone.
  - req_ready=1 from the first cycle after rst_b release.

Optional Feature:
- MISALIGNED_SPLIT_EN defined: split accesses handled as above.
- Undefined: any split request is treated as illegal (resp_err=1 at cycle 1, no memory access); RD_B/WR_B are not built.
- Aligned behaviour is identical either way.

Test Plan:
- LW 0x100, mem[0x100..0x103]={78,56,34,12} -> resp_valid at cycle 2, resp_rdata=0x12345678, mem_write_en never 1.
- mem[0x103]=0x80: LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; each at cycle 2.
- SB 0x101 wdata=0xAB, word 0x100=0x11223344 -> cycle 1 read 0x100, cycle 2 write 0x1122AB44, resp cycle 3.
- LW 0x102, words 0x100=0xDDCCBBAA, 0x104=0x44332211:
  - with MISALIGNED_SPLIT_EN: rdata=0x2211DDCC at cycle 3.
  - without: resp_err=1 at cycle 1, no mem access.
- SH 0xFFFFFFFF wdata=0xBEEF (EN defined) -> write 0xFFFFFFFC lane3=0xEF, then 0x00000000 lane0=0xBE, other lanes preserved, resp cycle 5.
- funct3=111 -> resp_err=1 at cycle 1, no mem access.
- Assert rst_b=0 during RD_B of a split store -> mem_write_en stays 0, no resp_valid; req_ready=1 the cycle after release.
